fd_adder2comp: RTL and testbench

Datapath (FD) for the two's-complement adder, controlled by the existing `UC_Adder2comp` control unit. It consumes the UC strobes `loadAB`, `loadmagAB`, `compmag`, `compsigns`, `add_sub`, `loadres` and `done`, and performs the arithmetic in sign-magnitude form. It returns status (`mag_ge`, `signs_eq`, `seq_err`) and a registered N+1-bit two's-complement result. A built-in sequence tracker rejects strobes that arrive out of protocol order.

---
 rtl/fd_adder2comp_pkg.sv | 17 +
 rtl/fd_adder2comp_mag_2comp.sv | 15 +
 rtl/fd_adder2comp.sv | 181 ++++++++++++++++++
 tb/tb_fd_adder2comp.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fd_adder2comp_pkg.sv
// Shared definitions for the two's-complement adder datapath and its
// control unit: default operand width and the 3-bit sequence-tracker
// state encodings. The control unit and its bench import the same package.
package fd_adder2comp_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [2:0] {
    TRK_IDLE   = 3'd0,
    TRK_LOADED = 3'd1,
    TRK_MAG    = 3'd2,
    TRK_CMP    = 3'd3,
    TRK_SUM    = 3'd4,
    TRK_RES    = 3'd5
  } trk_state_e;

endpackage

// File: rtl/fd_adder2comp_mag_2comp.sv
// mag_2comp: combinational N-bit two's complement to N-bit unsigned magnitude.
// The most negative value maps to 2^(N-1), which still fits as unsigned.
// Ports:
//   x_i   : N-bit two's-complement input
//   mag_o : N-bit unsigned magnitude |x_i|
module mag_2comp #(
  parameter int N = 8
) (
  input  logic [N-1:0] x_i,
  output logic [N-1:0] mag_o
);

  assign mag_o = x_i[N-1] ? (~x_i + N'(1)) : x_i;

endmodule

// File: rtl/fd_adder2comp.sv
// fd_adder2comp: datapath for the two's-complement adder driven by the
// UC_Adder2comp control unit. Arithmetic is done in sign-magnitude form and
// a sequence tracker rejects strobes that arrive out of protocol order.
// Ports:
//   clk, RESET        : clock, synchronous active-high reset
//   A_in, B_in        : operands, sampled on loadAB
//   loadAB..done      : control-unit strobes
//   res               : registered N+1-bit two's-complement result
//   res_valid         : res is final (set by done, cleared by loadAB)
//   ovf               : res does not fit in N bits
//   mag_ge, signs_eq  : registered compare status
//   seq_err           : sticky protocol-violation flag
module fd_adder2comp
  import fd_adder2comp_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic [N-1:0] A_in,
  input  logic [N-1:0] B_in,
  input  logic         loadAB,
  input  logic         loadmagAB,
  input  logic         compmag,
  input  logic         compsigns,
  input  logic         add_sub,
  input  logic         loadres,
  input  logic         done,
  output logic [N:0]   res,
  output logic         res_valid,
  output logic         ovf,
  output logic         mag_ge,
  output logic         signs_eq,
  output logic         seq_err
);

  trk_state_e   trk_q;
  logic [N-1:0] a_q, b_q;
  logic         sa_q, sb_q;
  logic [N-1:0] mag_a_q, mag_b_q;
  logic [N:0]   sum_mag_q;
  logic         sum_sign_q;
  logic [N:0]   res_q;
  logic         res_valid_q, ovf_q, mag_ge_q, signs_eq_q, seq_err_q;
  logic         cm_done_q, cs_done_q;

  logic [N-1:0] mag_a_w, mag_b_w;

  mag_2comp #(.N(N)) u_mag_a (.x_i(a_q), .mag_o(mag_a_w));
  mag_2comp #(.N(N)) u_mag_b (.x_i(b_q), .mag_o(mag_b_w));

  // Strobe decode. loadAB always wins; otherwise only a single strobe or
  // the compmag+compsigns pair is a well-formed cycle.
  logic [5:0] others_w;
  logic       cmp_pair_w, multi_w;
  logic       ok_mag_w, ok_cmp_w, ok_as_w, ok_lr_w, ok_done_w, illegal_w;

  assign others_w   = {loadmagAB, compmag, compsigns, add_sub, loadres, done};
  assign cmp_pair_w = (others_w == 6'b011000);
  assign multi_w    = ($countones(others_w) > 1) && !cmp_pair_w;

  // Each strobe is also legal in the state it moves the tracker into, so a
  // held strobe is an idempotent recompute rather than an error.
  assign ok_mag_w  = (trk_q == TRK_LOADED) || (trk_q == TRK_MAG);
  assign ok_cmp_w  = (trk_q == TRK_MAG) || (trk_q == TRK_CMP);
  assign ok_as_w   = ((trk_q == TRK_CMP) && cm_done_q && cs_done_q) || (trk_q == TRK_SUM);
  assign ok_lr_w   = (trk_q == TRK_SUM) || (trk_q == TRK_RES);
  assign ok_done_w = (trk_q == TRK_RES);

  assign illegal_w = (|others_w) &&
                     (multi_w ||
                      (loadmagAB && !ok_mag_w) ||
                      ((compmag || compsigns) && !ok_cmp_w) ||
                      (add_sub && !ok_as_w) ||
                      (loadres && !ok_lr_w) ||
                      (done && !ok_done_w));

  // Sign-magnitude add/subtract using the registered compare flags.
  logic [N:0] mag_a_ext_w, mag_b_ext_w, sum_mag_d;
  logic       sum_sign_d;

  assign mag_a_ext_w = {1'b0, mag_a_q};
  assign mag_b_ext_w = {1'b0, mag_b_q};

  always_comb begin
    sum_mag_d  = '0;
    sum_sign_d = 1'b0;
    if (signs_eq_q) begin
      sum_mag_d  = mag_a_ext_w + mag_b_ext_w;
      sum_sign_d = sa_q;
    end else if (mag_ge_q) begin
      sum_mag_d  = mag_a_ext_w - mag_b_ext_w;
      sum_sign_d = sa_q;
    end else begin
      sum_mag_d  = mag_b_ext_w - mag_a_ext_w;
      sum_sign_d = sb_q;
    end
    // Keep zero positive so the result never encodes "-0".
    if (sum_mag_d == '0) begin
      sum_sign_d = 1'b0;
    end
  end

  logic [N:0] res_d;
  logic       ovf_d;

  assign res_d = sum_sign_q ? (~sum_mag_q + (N+1)'(1)) : sum_mag_q;
  assign ovf_d = res_d[N] ^ res_d[N-1];

  always_ff @(posedge clk) begin
    if (RESET) begin
      trk_q       <= TRK_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      sum_mag_q   <= '0;
      sum_sign_q  <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      mag_ge_q    <= 1'b0;
      signs_eq_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      cm_done_q   <= 1'b0;
      cs_done_q   <= 1'b0;
    end else if (loadAB) begin
      a_q         <= A_in;
      b_q         <= B_in;
      sa_q        <= A_in[N-1];
      sb_q        <= B_in[N-1];
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      seq_err_q   <= 1'b0;
      cm_done_q   <= 1'b0;
      cs_done_q   <= 1'b0;
      trk_q       <= TRK_LOADED;
    end else if (illegal_w) begin
      seq_err_q <= 1'b1;
    end else begin
      if (loadmagAB) begin
        mag_a_q <= mag_a_w;
        mag_b_q <= mag_b_w;
        trk_q   <= TRK_MAG;
      end
      if (compmag) begin
        mag_ge_q  <= (mag_a_q >= mag_b_q);
        cm_done_q <= 1'b1;
        trk_q     <= TRK_CMP;
      end
      if (compsigns) begin
        signs_eq_q <= (sa_q == sb_q);
        cs_done_q  <= 1'b1;
        trk_q      <= TRK_CMP;
      end
      if (add_sub) begin
        sum_mag_q  <= sum_mag_d;
        sum_sign_q <= sum_sign_d;
        trk_q      <= TRK_SUM;
      end
      if (loadres) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        trk_q <= TRK_RES;
      end
      if (done) begin
        res_valid_q <= 1'b1;
      end
    end
  end

  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign ovf       = ovf_q;
  assign mag_ge    = mag_ge_q;
  assign signs_eq  = signs_eq_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_fd_adder2comp.sv
// Bench for fd_adder2comp (N=8). Expected results come from plain integer
// arithmetic on the signed operands: res is A+B truncated to 9 bits, ovf is
// A+B outside the 8-bit signed range, and the flags compare |A|,|B| and signs.
module tb_fd_adder2comp;

  logic       clk = 1'b0;
  logic       RESET;
  logic [7:0] A_in, B_in;
  logic       loadAB, loadmagAB, compmag, compsigns, add_sub, loadres, done;
  logic [8:0] res;
  logic       res_valid, ovf, mag_ge, signs_eq, seq_err;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] S_LOAD = 7'b1000000;
  localparam logic [6:0] S_MAG  = 7'b0100000;
  localparam logic [6:0] S_CM   = 7'b0010000;
  localparam logic [6:0] S_CS   = 7'b0001000;
  localparam logic [6:0] S_AS   = 7'b0000100;
  localparam logic [6:0] S_LR   = 7'b0000010;
  localparam logic [6:0] S_DONE = 7'b0000001;

  fd_adder2comp #(.N(8)) dut (
    .clk(clk), .RESET(RESET), .A_in(A_in), .B_in(B_in),
    .loadAB(loadAB), .loadmagAB(loadmagAB), .compmag(compmag),
    .compsigns(compsigns), .add_sub(add_sub), .loadres(loadres), .done(done),
    .res(res), .res_valid(res_valid), .ovf(ovf), .mag_ge(mag_ge),
    .signs_eq(signs_eq), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Reference model
  function automatic int sval(input logic [7:0] v);
    return int'($signed(v));
  endfunction
  function automatic int absval(input logic [7:0] v);
    int x;
    x = sval(v);
    return (x < 0) ? -x : x;
  endfunction
  function automatic logic [8:0] m_res(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = sval(a) + sval(b);
    return 9'(s);
  endfunction
  function automatic logic m_ovf(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = sval(a) + sval(b);
    return (s > 127) || (s < -128);
  endfunction
  function automatic logic m_ge(input logic [7:0] a, input logic [7:0] b);
    return absval(a) >= absval(b);
  endfunction
  function automatic logic m_seq(input logic [7:0] a, input logic [7:0] b);
    return (sval(a) < 0) == (sval(b) < 0);
  endfunction

  // Drive one strobe cycle; outputs are settled when this returns.
  task automatic step(input logic [6:0] s);
    @(negedge clk);
    {loadAB, loadmagAB, compmag, compsigns, add_sub, loadres, done} = s;
    @(posedge clk);
    #1;
    {loadAB, loadmagAB, compmag, compsigns, add_sub, loadres, done} = '0;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    A_in = a;
    B_in = b;
    step(S_LOAD);
    A_in = $urandom;
    B_in = $urandom;
  endtask

  // order: 0 compmag first, 1 compsigns first, 2 both in one cycle
  task automatic run_seq(input logic [7:0] a, input logic [7:0] b,
                         input int order, input bit with_done);
    load(a, b);
    step(S_MAG);
    case (order)
      0:       begin step(S_CM); step(S_CS); end
      1:       begin step(S_CS); step(S_CM); end
      default: step(S_CM | S_CS);
    endcase
    step(S_AS);
    step(S_LR);
    if (with_done) step(S_DONE);
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({res, res_valid, ovf, mag_ge, signs_eq, seq_err} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got res=%h rv=%b ovf=%b ge=%b seq=%b err=%b, want all 0",
               res, res_valid, ovf, mag_ge, signs_eq, seq_err);
    end
    @(negedge clk);
    RESET = 1'b0;
  endtask

  task automatic test_directed;
    logic [7:0] av [4] = '{8'd5, 8'h9C, 8'h80, 8'd7};
    logic [7:0] bv [4] = '{8'hFD, 8'h9C, 8'd127, 8'hF9};
    for (int i = 0; i < 4; i++) begin
      run_seq(av[i], bv[i], 0, 1'b0);
      total++;
      if (res !== m_res(av[i], bv[i]) || ovf !== m_ovf(av[i], bv[i]) || res_valid !== 1'b0) begin
        bad++;
        $display("FAIL directed_res[%0d]: got res=%h ovf=%b rv=%b, want res=%h ovf=%b rv=0",
                 i, res, ovf, res_valid, m_res(av[i], bv[i]), m_ovf(av[i], bv[i]));
      end
      step(S_DONE);
      total++;
      if (res_valid !== 1'b1 || mag_ge !== m_ge(av[i], bv[i]) ||
          signs_eq !== m_seq(av[i], bv[i]) || seq_err !== 1'b0) begin
        bad++;
        $display("FAIL directed_flags[%0d]: got rv=%b ge=%b seq=%b err=%b, want rv=1 ge=%b seq=%b err=0",
                 i, res_valid, mag_ge, signs_eq, seq_err, m_ge(av[i], bv[i]), m_seq(av[i], bv[i]));
      end
      $display("directed %0d: A=%0d B=%0d res=%h ovf=%b", i, sval(av[i]), sval(bv[i]), res, ovf);
    end
  endtask

  task automatic test_order_variants;
    logic [7:0] a, b;
    for (int ord = 1; ord <= 2; ord++) begin
      a = $urandom;
      b = $urandom;
      run_seq(a, b, ord, 1'b1);
      total++;
      if (res !== m_res(a, b) || ovf !== m_ovf(a, b) || res_valid !== 1'b1 || seq_err !== 1'b0) begin
        bad++;
        $display("FAIL order_variant[%0d]: got res=%h ovf=%b rv=%b err=%b, want res=%h ovf=%b rv=1 err=0",
                 ord, res, ovf, res_valid, seq_err, m_res(a, b), m_ovf(a, b));
      end
      $display("order %0d: A=%0d B=%0d res=%h", ord, sval(a), sval(b), res);
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    int ord;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) begin a = 8'h80; b = 8'h80; end
      ord = $urandom_range(0, 2);
      run_seq(a, b, ord, 1'b1);
      total++;
      if (res !== m_res(a, b) || ovf !== m_ovf(a, b)) begin
        bad++;
        $display("FAIL random_res[%0d]: A=%h B=%h got res=%h ovf=%b, want res=%h ovf=%b",
                 i, a, b, res, ovf, m_res(a, b), m_ovf(a, b));
      end
      total++;
      if (mag_ge !== m_ge(a, b) || signs_eq !== m_seq(a, b) || res_valid !== 1'b1 || seq_err !== 1'b0) begin
        bad++;
        $display("FAIL random_flags[%0d]: A=%h B=%h got ge=%b seq=%b rv=%b err=%b, want ge=%b seq=%b rv=1 err=0",
                 i, a, b, mag_ge, signs_eq, res_valid, seq_err, m_ge(a, b), m_seq(a, b));
      end
      $display("random %0d: A=%0d B=%0d order=%0d res=%h ovf=%b", i, sval(a), sval(b), ord, res, ovf);
    end
  endtask

  task automatic test_seq_err_mag;
    logic [8:0] prev;
    run_seq(8'd20, 8'd30, 0, 1'b1);
    prev = m_res(8'd20, 8'd30);
    load(8'd3, 8'd4);
    step(S_MAG);
    step(S_AS);
    total++;
    if (seq_err !== 1'b1 || res !== prev) begin
      bad++;
      $display("FAIL addsub_in_mag: got err=%b res=%h, want err=1 res=%h", seq_err, res, prev);
    end
    // Tracker must still be in MAG: finishing the order gives the right sum.
    step(S_CM); step(S_CS); step(S_AS); step(S_LR);
    total++;
    if (res !== m_res(8'd3, 8'd4) || seq_err !== 1'b1) begin
      bad++;
      $display("FAIL after_illegal: got res=%h err=%b, want res=%h err=1 (sticky)",
               res, seq_err, m_res(8'd3, 8'd4));
    end
    load(8'd1, 8'd1);
    total++;
    if (seq_err !== 1'b0) begin
      bad++;
      $display("FAIL load_clears_err: got err=%b, want 0", seq_err);
    end
    $display("seq_err_mag: illegal add_sub rejected, cleared by loadAB");
  endtask

  task automatic test_multi_strobe;
    load(8'd50, 8'hF0);
    step(S_MAG);
    step(S_CM | S_AS);
    total++;
    if (seq_err !== 1'b1) begin
      bad++;
      $display("FAIL multi_strobe: got err=%b, want 1", seq_err);
    end
    $display("multi_strobe: compmag+add_sub -> err=%b", seq_err);
  endtask

  task automatic test_load_priority;
    A_in = 8'hE2;
    B_in = 8'd100;
    step(S_LOAD | S_AS);
    total++;
    if (seq_err !== 1'b0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL load_priority: got err=%b rv=%b, want err=0 rv=0", seq_err, res_valid);
    end
    step(S_MAG); step(S_CM); step(S_CS); step(S_AS); step(S_LR); step(S_DONE);
    total++;
    if (res !== m_res(8'hE2, 8'd100) || seq_err !== 1'b0 || res_valid !== 1'b1) begin
      bad++;
      $display("FAIL load_priority_seq: got res=%h err=%b rv=%b, want res=%h err=0 rv=1",
               res, seq_err, res_valid, m_res(8'hE2, 8'd100));
    end
    $display("load_priority: res=%h err=%b", res, seq_err);
  endtask

  task automatic test_back_to_back;
    run_seq(8'h9C, 8'h9C, 0, 1'b1);
    step(S_DONE);
    step(S_DONE);
    total++;
    if (res_valid !== 1'b1 || seq_err !== 1'b0 || ovf !== 1'b1 || res !== 9'h138) begin
      bad++;
      $display("FAIL done_held: got rv=%b err=%b ovf=%b res=%h, want rv=1 err=0 ovf=1 res=138",
               res_valid, seq_err, ovf, res);
    end
    load(8'd9, 8'd10);
    total++;
    if (res_valid !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL load_clears_valid: got rv=%b ovf=%b, want 0 0", res_valid, ovf);
    end
    run_seq(8'd9, 8'd10, 2, 1'b1);
    total++;
    if (res !== m_res(8'd9, 8'd10) || res_valid !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back: got res=%h rv=%b, want res=%h rv=1", res, res_valid, m_res(8'd9, 8'd10));
    end
    $display("back_to_back: res=%h", res);
  endtask

  task automatic test_reset_mid;
    load(8'd60, 8'd61);
    step(S_MAG); step(S_CM); step(S_CS); step(S_AS);
    @(negedge clk);
    RESET = 1'b1;
    step(S_LR);
    RESET = 1'b0;
    total++;
    if ({res, res_valid, ovf, mag_ge, signs_eq, seq_err} !== 14'd0) begin
      bad++;
      $display("FAIL reset_mid: got res=%h rv=%b ovf=%b ge=%b seq=%b err=%b, want all 0",
               res, res_valid, ovf, mag_ge, signs_eq, seq_err);
    end
    step(S_LR);
    total++;
    if (seq_err !== 1'b1 || res !== 9'd0) begin
      bad++;
      $display("FAIL loadres_in_idle: got err=%b res=%h, want err=1 res=000", seq_err, res);
    end
    $display("reset_mid: err=%b res=%h", seq_err, res);
  endtask

  initial begin
    RESET = 1'b1;
    A_in = '0;
    B_in = '0;
    {loadAB, loadmagAB, compmag, compsigns, add_sub, loadres, done} = '0;
    test_reset();
    test_directed();
    test_order_variants();
    test_random();
    test_seq_err_mag();
    test_multi_strobe();
    test_load_priority();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
